wb_timeout_guard: RTL and testbench
===================================

# wb_timeout_guard

Bus-watchdog stage placed between the `wishbone_arbitrator` peripheral-side port and the `wishbone_decoder`. It forwards every granted Wishbone cycle unchanged, counts stall cycles, and when a selected peripheral (team project, LA, GPIO or SRAM) fails to acknowledge within a bounded time, it aborts the downstream cycle. In that case it returns a fake acknowledge carrying a marker word to the manager, so a hung or unpopulated address can never lock up the management SoC. Error status is latched for firmware and debug visibility.

## Interface
- `TIMEOUT_CYCLES`, default 255: stall cycles tolerated before abort. Legal range is 2..2^`TIMEOUT_W`-1.
- `TIMEOUT_W`, default 8: width of the stall counter.
- `DEAD_DATA`, default 32'hBADC_0FFE: read data returned on a timed-out cycle.
- `CLK` in 1: bus clock (`wb_clk_i`).
- `nRST` in 1: reset, asynchronous, active-low.
- `u_cyc_i` in 1, `u_stb_i` in 1, `u_we_i` in 1, `u_sel_i` in 4, `u_adr_i` in 32, `u_dat_i` in 32: request from the arbitrator.
- `u_ack_o` out 1, `u_dat_o` out 32: response to the arbitrator.
- `d_cyc_o` out 1, `d_stb_o` out 1, `d_we_o` out 1, `d_sel_o` out 4, `d_adr_o` out 32, `d_dat_o` out 32: request to the decoder.
- `d_ack_i` in 1, `d_dat_i` in 32: muxed response from the decoder.
- `err_clr_i` in 1: single-cycle clear of all error status.
- `err_o` out 1: sticky flag, set on any timeout.
- `err_irq_o` out 1: one-cycle pulse per timeout.
- `err_cnt_o` out 8: timeout count, saturating at 255.
- `err_adr_o` out 32: `u_adr_i` of the most recent timed-out cycle.

## Operation
- States: PASS (reset state), ERR, DRAIN.
- PASS:
  - `d_*` request outputs equal the `u_*` inputs combinationally.
  - `u_ack_o` = `d_ack_i`; `u_dat_o` = `d_dat_i`.
- Stall counter `cnt`:
  - Increments on each cycle with `u_cyc_i & u_stb_i & !d_ack_i`.
  - Clears on `d_ack_i`, or when `u_cyc_i & u_stb_i` is 0.
  - Never wraps.
- Timeout: in PASS, when `cnt == TIMEOUT_CYCLES-1` and the increment condition holds, the next state is ERR.
- ERR (exactly one cycle):
  - `d_cyc_o` = `d_stb_o` = 0.
  - `u_ack_o` = 1 and `u_dat_o` = `DEAD_DATA`, regardless of `u_we_i`.
  - `d_ack_i` is ignored.
  - `err_o` set to 1.
  - `err_irq_o` = 1 on this cycle.
  - `err_cnt_o` incremented, saturating.
  - `err_adr_o` loaded with `u_adr_i`.
  - Next state is DRAIN.
- DRAIN:
  - `d_cyc_o` = `d_stb_o` = 0 and `u_ack_o` = 0.
  - A late `d_ack_i` is swallowed.
  - Returns to PASS once `u_stb_i == 0` or `u_cyc_i == 0`, with `cnt` = 0.
- `err_clr_i` zeroes `err_o`, `err_cnt_o` and `err_adr_o`.
  - Simultaneous with ERR entry: the timeout wins. Results are `err_o` = 1, `err_cnt_o` = 1, `err_adr_o` = new address.
- A `d_ack_i` arriving in the same cycle that `cnt` reaches the limit is a normal ack. No timeout is raised.
- Non-`d_*`/`u_*` outputs are registered. The only combinational paths are the PASS-state pass-through.

## Timing
- Normal-path latency is 0 cycles in both directions; no bubble is inserted.
- Timed-out cycle: the manager sees `u_ack_o` on stall cycle `TIMEOUT_CYCLES+1`, counted from the first `u_stb_i` cycle.
- After DRAIN, a back-to-back request is accepted in the first PASS cycle.
- Reset values:
  - State is PASS and `cnt` = 0.
  - `err_o`, `err_irq_o`, `err_cnt_o` and `err_adr_o` are 0.
  - Pass-through outputs follow their inputs.
- Reset asserted mid-stall or mid-DRAIN: the abort is silent, with no ack and no error recorded. The downstream cycle is forwarded again immediately if upstream still asserts it.

## Structure
- Shared package `wb_guard_pkg` holds:
  - `wb_guard_state_t` enum {PASS, ERR, DRAIN}.
  - `WB_GUARD_DEAD_DATA` constant (the parameter default).
  - `WB_GUARD_ERRCNT_W` = 8.
- One sub-module, `wb_guard_status`, holds the sticky flag, saturating counter, address capture and IRQ pulse.
  - Inputs: `timeout_evt`, `adr`, `clr`.
- FSM, stall counter and muxing live in the top.

## Test plan
All scenarios use `TIMEOUT_CYCLES` = 8.
- Read to 0x3000_0004, `d_ack_i` on the 3rd stall cycle with `d_dat_i` = 0x1234_5678 -> `u_ack_o` on the same cycle, `u_dat_o` = 0x1234_5678, `err_o` = 0.
- Request with no `d_ack_i` -> on cycle 9, `u_ack_o` = 1, `u_dat_o` = 0xBADC_0FFE, `d_cyc_o` = 0, `err_irq_o` pulses once, `err_cnt_o` = 1, `err_adr_o` = request address.
- Timeout, then `d_ack_i` asserted during DRAIN -> no second `u_ack_o`. The next request, at 0x3000_0008, completes normally.
- `d_ack_i` exactly on stall cycle 8 -> normal ack, `err_cnt_o` unchanged.
- 300 timeouts -> `err_cnt_o` = 255. `err_clr_i` -> all status reads 0. `err_clr_i` coincident with timeout -> `err_cnt_o` = 1.
- `nRST` low on stall cycle 5 -> no ack and status stays 0. After release, `cnt` restarts from 0.

Source files
------------

// File: rtl/wb_guard_pkg.sv
// Shared types and constants for the Wishbone timeout guard.
package wb_guard_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        ERR   = 2'd1,
        DRAIN = 2'd2
    } wb_guard_state_t;

    localparam logic [31:0] WB_GUARD_DEAD_DATA = 32'hBADC_0FFE;
    localparam int unsigned WB_GUARD_ERRCNT_W  = 8;

endpackage

// File: rtl/wb_guard_status.sv
// Firmware-visible timeout status: sticky flag, saturating count,
// captured address of the last timed-out cycle and a one-cycle IRQ pulse.
module wb_guard_status
    import wb_guard_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         timeout_evt,
    input  logic [31:0]                  adr,
    input  logic                         clr,
    output logic                         err,
    output logic                         irq,
    output logic [WB_GUARD_ERRCNT_W-1:0] err_cnt,
    output logic [31:0]                  err_adr
);

    localparam logic [WB_GUARD_ERRCNT_W-1:0] CNT_MAX = '1;

    logic                         err_q, err_d;
    logic                         irq_q, irq_d;
    logic [WB_GUARD_ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]                  err_adr_q, err_adr_d;

    // A timeout in the same cycle as a clear wins: the clear only wipes history.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        irq_d     = timeout_evt;
        if (timeout_evt) begin
            err_d     = 1'b1;
            err_adr_d = adr;
            if (clr) begin
                err_cnt_d = WB_GUARD_ERRCNT_W'(1);
            end else if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (clr) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
            err_adr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            err_q     <= err_d;
            irq_q     <= irq_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign err     = err_q;
    assign irq     = irq_q;
    assign err_cnt = err_cnt_q;
    assign err_adr = err_adr_q;

endmodule

// File: rtl/wb_timeout_guard.sv
// Wishbone watchdog between arbitrator and decoder: forwards cycles untouched
// and fakes an ack with a marker word when a peripheral stalls too long.
module wb_timeout_guard
    import wb_guard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8,
    parameter logic [31:0] DEAD_DATA      = WB_GUARD_DEAD_DATA
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         u_cyc_i,
    input  logic                         u_stb_i,
    input  logic                         u_we_i,
    input  logic [3:0]                   u_sel_i,
    input  logic [31:0]                  u_adr_i,
    input  logic [31:0]                  u_dat_i,
    output logic                         u_ack_o,
    output logic [31:0]                  u_dat_o,
    output logic                         d_cyc_o,
    output logic                         d_stb_o,
    output logic                         d_we_o,
    output logic [3:0]                   d_sel_o,
    output logic [31:0]                  d_adr_o,
    output logic [31:0]                  d_dat_o,
    input  logic                         d_ack_i,
    input  logic [31:0]                  d_dat_i,
    input  logic                         err_clr_i,
    output logic                         err_o,
    output logic                         err_irq_o,
    output logic [WB_GUARD_ERRCNT_W-1:0] err_cnt_o,
    output logic [31:0]                  err_adr_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;

    wb_guard_state_t      state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 req;
    logic                 stall;
    logic                 timeout_evt;

    assign req   = u_cyc_i & u_stb_i;
    assign stall = req & ~d_ack_i;

    // An ack landing on the limit cycle clears the stall, so it is never a timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_evt = 1'b0;
        unique case (state_q)
            PASS: begin
                if (!stall) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_evt = 1'b1;
                    state_d     = ERR;
                    cnt_d       = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            DRAIN: begin
                cnt_d = '0;
                if (!req) begin
                    state_d = PASS;
                end
            end
            default: begin
                state_d = PASS;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= PASS;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outside PASS the downstream strobe is cut and the decoder's response ignored.
    always_comb begin
        d_cyc_o = 1'b0;
        d_stb_o = 1'b0;
        d_we_o  = u_we_i;
        d_sel_o = u_sel_i;
        d_adr_o = u_adr_i;
        d_dat_o = u_dat_i;
        u_ack_o = 1'b0;
        u_dat_o = d_dat_i;
        unique case (state_q)
            PASS: begin
                d_cyc_o = u_cyc_i;
                d_stb_o = u_stb_i;
                u_ack_o = d_ack_i;
            end
            ERR: begin
                u_ack_o = 1'b1;
                u_dat_o = DEAD_DATA;
            end
            default: begin
                u_ack_o = 1'b0;
            end
        endcase
    end

    wb_guard_status u_status (
        .clk         (CLK),
        .rst_n       (nRST),
        .timeout_evt (timeout_evt),
        .adr         (u_adr_i),
        .clr         (err_clr_i),
        .err         (err_o),
        .irq         (err_irq_o),
        .err_cnt     (err_cnt_o),
        .err_adr     (err_adr_o)
    );

endmodule

// File: tb/tb_wb_timeout_guard.sv
// Self-checking bench for wb_timeout_guard: a fixed vector table, directed
// corner sequences and randomized traffic against a transaction-level model.
module tb_wb_timeout_guard;

    localparam int          T    = 8;
    localparam logic [31:0] DEAD = 32'hBADC_0FFE;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        u_cyc_i = 1'b0, u_stb_i = 1'b0, u_we_i = 1'b0;
    logic [3:0]  u_sel_i = '0;
    logic [31:0] u_adr_i = '0, u_dat_i = '0;
    logic        u_ack_o;
    logic [31:0] u_dat_o;
    logic        d_cyc_o, d_stb_o, d_we_o;
    logic [3:0]  d_sel_o;
    logic [31:0] d_adr_o, d_dat_o;
    logic        d_ack_i = 1'b0;
    logic [31:0] d_dat_i = '0;
    logic        err_clr_i = 1'b0;
    logic        err_o, err_irq_o;
    logic [7:0]  err_cnt_o;
    logic [31:0] err_adr_o;

    int vectors = 0;
    int miscompares = 0;

    wb_timeout_guard #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(8), .DEAD_DATA(DEAD)) dut (
        .CLK(CLK), .nRST(nRST),
        .u_cyc_i(u_cyc_i), .u_stb_i(u_stb_i), .u_we_i(u_we_i), .u_sel_i(u_sel_i),
        .u_adr_i(u_adr_i), .u_dat_i(u_dat_i), .u_ack_o(u_ack_o), .u_dat_o(u_dat_o),
        .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o), .d_we_o(d_we_o), .d_sel_o(d_sel_o),
        .d_adr_o(d_adr_o), .d_dat_o(d_dat_o), .d_ack_i(d_ack_i), .d_dat_i(d_dat_i),
        .err_clr_i(err_clr_i), .err_o(err_o), .err_irq_o(err_irq_o),
        .err_cnt_o(err_cnt_o), .err_adr_o(err_adr_o)
    );

    always #5 CLK = ~CLK;

    // Reference model: length of the current stall run, plus two flags for
    // "fake ack due now" and "waiting for the manager to let go".
    int          m_stalled;
    bit          m_fake_ack, m_wait_drop;
    bit          m_err;
    int          m_cnt;
    logic [31:0] m_adr;

    typedef struct {
        bit          cyc, stb;
        logic [31:0] adr;
        bit          d_ack;
        logic [31:0] d_dat;
        bit          exp_ack;
        logic [31:0] exp_dat;
        bit          exp_dcyc, exp_err, exp_irq;
        int          exp_cnt;
        logic [31:0] exp_eadr;
    } vec_t;

    vec_t tbl[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_stalled = 0; m_fake_ack = 0; m_wait_drop = 0;
        m_err = 0; m_cnt = 0; m_adr = '0;
    endtask

    task automatic model_clock();
        bit req;
        bit fire;
        req  = u_cyc_i && u_stb_i;
        fire = 0;
        if (m_fake_ack) begin
            m_fake_ack = 0; m_wait_drop = 1; m_stalled = 0;
        end else if (m_wait_drop) begin
            if (!req) m_wait_drop = 0;
        end else if (req && !d_ack_i) begin
            m_stalled++;
            if (m_stalled == T) begin
                fire = 1; m_fake_ack = 1; m_stalled = 0;
            end
        end else begin
            m_stalled = 0;
        end
        if (fire) begin
            m_err = 1;
            m_adr = u_adr_i;
            m_cnt = err_clr_i ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
        end else if (err_clr_i) begin
            m_err = 0; m_cnt = 0; m_adr = '0;
        end
    endtask

    task automatic model_check();
        if (m_fake_ack) begin
            check_output("ack_fake", 32'(u_ack_o), 32'd1);
            check_output("dat_fake", u_dat_o, DEAD);
            check_output("dcyc_cut", 32'(d_cyc_o), 32'd0);
            check_output("dstb_cut", 32'(d_stb_o), 32'd0);
        end else if (m_wait_drop) begin
            check_output("ack_drain", 32'(u_ack_o), 32'd0);
            check_output("dcyc_drain", 32'(d_cyc_o), 32'd0);
            check_output("dstb_drain", 32'(d_stb_o), 32'd0);
        end else begin
            check_output("ack_pass", 32'(u_ack_o), 32'(d_ack_i));
            check_output("dat_pass", u_dat_o, d_dat_i);
            check_output("dcyc_pass", 32'(d_cyc_o), 32'(u_cyc_i));
            check_output("dstb_pass", 32'(d_stb_o), 32'(u_stb_i));
            check_output("dwe_pass", 32'(d_we_o), 32'(u_we_i));
            check_output("dsel_pass", 32'(d_sel_o), 32'(u_sel_i));
            check_output("dadr_pass", d_adr_o, u_adr_i);
            check_output("ddat_pass", d_dat_o, u_dat_i);
        end
        check_output("err_irq", 32'(err_irq_o), 32'(m_fake_ack));
        check_output("err", 32'(err_o), 32'(m_err));
        check_output("err_cnt", 32'(err_cnt_o), 32'(m_cnt));
        check_output("err_adr", err_adr_o, m_adr);
    endtask

    task automatic drive(input bit cyc, input bit stb, input logic [31:0] adr,
                         input bit ack, input logic [31:0] ddat, input bit clr);
        u_cyc_i = cyc; u_stb_i = stb; u_we_i = 1'($urandom);
        u_sel_i = 4'($urandom); u_adr_i = adr; u_dat_i = $urandom;
        d_ack_i = ack; d_dat_i = ddat; err_clr_i = clr;
    endtask

    task automatic apply_stimulus(input bit cyc, input bit stb, input logic [31:0] adr,
                                  input bit ack, input logic [31:0] ddat, input bit clr);
        @(negedge CLK);
        drive(cyc, stb, adr, ack, ddat, clr);
        #1;
        model_check();
        @(posedge CLK);
        model_clock();
    endtask

    task automatic timeout_request(input logic [31:0] adr, input bit clr_on_last);
        repeat (T - 1) apply_stimulus(1, 1, adr, 0, $urandom, 0);
        apply_stimulus(1, 1, adr, 0, $urandom, clr_on_last);
        apply_stimulus(1, 1, adr, 0, $urandom, 0);
        apply_stimulus(0, 0, '0, 0, $urandom, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        drive(0, 0, '0, 0, '0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        a = 32'h3000_0004; b = 32'h3000_0010; c = 32'h3000_0008;

        // Reset state.
        drive(1, 1, 32'h1111_2222, 0, 32'h5, 0);
        #2;
        check_output("rst_dcyc_follow", 32'(d_cyc_o), 32'd1);
        check_output("rst_dadr_follow", d_adr_o, 32'h1111_2222);
        check_output("rst_err", 32'(err_o), 32'd0);
        check_output("rst_irq", 32'(err_irq_o), 32'd0);
        check_output("rst_cnt", 32'(err_cnt_o), 32'd0);
        check_output("rst_eadr", err_adr_o, 32'd0);
        drive(0, 0, '0, 0, '0, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Normal read, then a full timeout with a late ack, then a fresh request.
        tbl.push_back('{0, 0, '0, 0, '0, 0, '0, 0, 0, 0, 0, '0});
        tbl.push_back('{1, 1, a, 0, '0, 0, '0, 1, 0, 0, 0, '0});
        tbl.push_back('{1, 1, a, 0, '0, 0, '0, 1, 0, 0, 0, '0});
        tbl.push_back('{1, 1, a, 1, 32'h1234_5678, 1, 32'h1234_5678, 1, 0, 0, 0, '0});
        tbl.push_back('{0, 0, '0, 0, '0, 0, '0, 0, 0, 0, 0, '0});
        for (int i = 0; i < T; i++)
            tbl.push_back('{1, 1, b, 0, '0, 0, '0, 1, 0, 0, 0, '0});
        tbl.push_back('{1, 1, b, 1, 32'h55, 1, DEAD, 0, 1, 1, 1, b});
        tbl.push_back('{1, 1, b, 1, 32'h66, 0, '0, 0, 1, 0, 1, b});
        tbl.push_back('{0, 0, '0, 1, 32'h77, 0, '0, 0, 1, 0, 1, b});
        tbl.push_back('{1, 1, c, 1, 32'hAA55_AA55, 1, 32'hAA55_AA55, 1, 1, 0, 1, b});
        tbl.push_back('{0, 0, '0, 0, '0, 0, '0, 0, 1, 0, 1, b});

        foreach (tbl[i]) begin
            @(negedge CLK);
            drive(tbl[i].cyc, tbl[i].stb, tbl[i].adr, tbl[i].d_ack, tbl[i].d_dat, 0);
            #1;
            check_output($sformatf("tbl%0d_ack", i), 32'(u_ack_o), 32'(tbl[i].exp_ack));
            if (tbl[i].exp_ack)
                check_output($sformatf("tbl%0d_dat", i), u_dat_o, tbl[i].exp_dat);
            check_output($sformatf("tbl%0d_dcyc", i), 32'(d_cyc_o), 32'(tbl[i].exp_dcyc));
            check_output($sformatf("tbl%0d_err", i), 32'(err_o), 32'(tbl[i].exp_err));
            check_output($sformatf("tbl%0d_irq", i), 32'(err_irq_o), 32'(tbl[i].exp_irq));
            check_output($sformatf("tbl%0d_cnt", i), 32'(err_cnt_o), 32'(tbl[i].exp_cnt));
            check_output($sformatf("tbl%0d_eadr", i), err_adr_o, tbl[i].exp_eadr);
        end

        do_reset();

        // Ack exactly on the limit stall cycle is a normal completion.
        repeat (T - 1) apply_stimulus(1, 1, a, 0, $urandom, 0);
        apply_stimulus(1, 1, a, 1, 32'hCAFE_0008, 0);
        apply_stimulus(0, 0, '0, 0, '0, 0);
        check_output("ack_on_limit_cnt", 32'(err_cnt_o), 32'd0);
        check_output("ack_on_limit_err", 32'(err_o), 32'd0);

        // Saturate the error counter, then clear it.
        for (int i = 0; i < 300; i++) timeout_request(32'h3000_0000 + 32'(i), 0);
        #1;
        check_output("sat_cnt", 32'(err_cnt_o), 32'd255);
        check_output("sat_eadr", err_adr_o, 32'h3000_0000 + 32'd299);
        apply_stimulus(0, 0, '0, 0, '0, 1);
        #1;
        check_output("clr_err", 32'(err_o), 32'd0);
        check_output("clr_cnt", 32'(err_cnt_o), 32'd0);
        check_output("clr_eadr", err_adr_o, 32'd0);

        // Clear coincident with a timeout: the timeout wins.
        timeout_request(32'h3000_0020, 0);
        timeout_request(32'h3000_0024, 1);
        #1;
        check_output("clr_coinc_cnt", 32'(err_cnt_o), 32'd1);
        check_output("clr_coinc_eadr", err_adr_o, 32'h3000_0024);

        // Reset on stall cycle 5: silent abort, counter restarts afterwards.
        repeat (4) apply_stimulus(1, 1, c, 0, $urandom, 0);
        @(negedge CLK);
        drive(1, 1, c, 0, '0, 0);
        #1;
        nRST = 1'b0;
        #1;
        check_output("rstmid_ack", 32'(u_ack_o), 32'd0);
        check_output("rstmid_dcyc", 32'(d_cyc_o), 32'd1);
        check_output("rstmid_err", 32'(err_o), 32'd0);
        check_output("rstmid_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        drive(1, 1, c, 0, '0, 0);
        #1;
        model_check();
        @(posedge CLK);
        model_clock();
        repeat (T - 1) apply_stimulus(1, 1, c, 0, $urandom, 0);
        apply_stimulus(1, 1, c, 0, $urandom, 0);
        apply_stimulus(0, 0, '0, 0, '0, 0);
        check_output("rstmid_late_cnt", 32'(err_cnt_o), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            bit req, cyc, stb;
            req = ($urandom_range(0, 19) != 0);
            cyc = req | 1'($urandom);
            stb = req | (!cyc & 1'($urandom));
            apply_stimulus(cyc, stb, $urandom, ($urandom_range(0, 10) == 0),
                           $urandom, ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
